// File: rtl/alu_pkg.sv
// Shared ALU definitions for the MIPS core: op-code widths and constants,
// opcode/funct encodings, and the decoded-control payload that travels from
// ID into EX.
package alu_pkg;

   localparam int unsigned ALU_OP_W = 4;
   localparam int unsigned OPC_W    = 6;
   localparam int unsigned FUNCT_W  = 6;

   // ALU operation codes
   localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0010;
   localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0110;
   localparam logic [ALU_OP_W-1:0] ALU_MUL = 4'b0000;
   localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'b0011;
   localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'b0111;
   localparam logic [ALU_OP_W-1:0] ALU_NOR = 4'b1100;
   localparam logic [ALU_OP_W-1:0] ALU_NOP = 4'b1111;

   // Primary opcodes, instruction[31:26]
   localparam logic [OPC_W-1:0] OPC_RTYPE = 6'h00;
   localparam logic [OPC_W-1:0] OPC_ADDI  = 6'h08;
   localparam logic [OPC_W-1:0] OPC_LW    = 6'h23;
   localparam logic [OPC_W-1:0] OPC_SW    = 6'h2B;
   localparam logic [OPC_W-1:0] OPC_SLTI  = 6'h0A;
   localparam logic [OPC_W-1:0] OPC_XORI  = 6'h0E;
   localparam logic [OPC_W-1:0] OPC_BEQ   = 6'h04;

   // R-type function codes, instruction[5:0]
   localparam logic [FUNCT_W-1:0] FN_ADD  = 6'h20;
   localparam logic [FUNCT_W-1:0] FN_SUB  = 6'h22;
   localparam logic [FUNCT_W-1:0] FN_MULT = 6'h18;
   localparam logic [FUNCT_W-1:0] FN_XOR  = 6'h26;
   localparam logic [FUNCT_W-1:0] FN_SLT  = 6'h2A;
   localparam logic [FUNCT_W-1:0] FN_NOR  = 6'h27;

   // Decoded control carried in the ID/EX register
   typedef struct packed {
      logic [ALU_OP_W-1:0] op;
      logic                alu_src;
      logic                trap;
      logic                illegal;
   } dec_t;

   // Control payload of a pipeline bubble
   function automatic dec_t dec_bubble(input logic [ALU_OP_W-1:0] nop_op);
      dec_t d;
      d.op      = nop_op;
      d.alu_src = 1'b0;
      d.trap    = 1'b0;
      d.illegal = 1'b0;
      return d;
   endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode/funct decoder producing the ALU operation code, the
// operand-2 source select, the overflow-trap enable and the illegal flag.
// Ports:
//   opcode, funct   instruction[31:26], instruction[5:0]
//   op_c            ALU operation code (NOP_OP when illegal)
//   alu_src_c       1 = operand_2 is the sign-extended immediate
//   trap_c          overflow on this instruction raises an exception
//   illegal_c       encoding not recognised
module alu_op_decode
   import alu_pkg::*;
#(
   parameter logic [ALU_OP_W-1:0] NOP_OP = ALU_NOP
) (
   input  logic [OPC_W-1:0]    opcode,
   input  logic [FUNCT_W-1:0]  funct,
   output logic [ALU_OP_W-1:0] op_c,
   output logic                alu_src_c,
   output logic                trap_c,
   output logic                illegal_c
);

   // Decode table; anything not matched falls through as illegal
   always_comb begin
      op_c      = NOP_OP;
      alu_src_c = 1'b0;
      trap_c    = 1'b0;
      illegal_c = 1'b1;
      case (opcode)
         OPC_RTYPE: begin
            illegal_c = 1'b0;
            case (funct)
               FN_ADD:  begin op_c = ALU_ADD; trap_c = 1'b1; end
               FN_SUB:  op_c = ALU_SUB;
               FN_MULT: op_c = ALU_MUL;
               FN_XOR:  op_c = ALU_XOR;
               FN_SLT:  op_c = ALU_SLT;
               FN_NOR:  op_c = ALU_NOR;
               default: illegal_c = 1'b1;
            endcase
         end
         OPC_ADDI: begin
            op_c = ALU_ADD; alu_src_c = 1'b1; trap_c = 1'b1; illegal_c = 1'b0;
         end
         OPC_LW, OPC_SW: begin
            op_c = ALU_ADD; alu_src_c = 1'b1; illegal_c = 1'b0;
         end
         OPC_SLTI: begin
            op_c = ALU_SLT; alu_src_c = 1'b1; illegal_c = 1'b0;
         end
         OPC_XORI: begin
            op_c = ALU_XOR; alu_src_c = 1'b1; illegal_c = 1'b0;
         end
         OPC_BEQ: begin
            op_c = ALU_SUB; illegal_c = 1'b0;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_op_issue.sv
// ID->EX issue stage: decodes the ID instruction, holds the ID/EX pipeline
// register (stall/flush aware) and turns EX-stage ALU overflow into a
// write-back kill plus a sticky exception record for the control unit.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   id_valid/opcode/funct/pc   ID-stage instruction
//   stall, flush               hold / bubble the EX register
//   alu_overflow               ALU overflow for the current EX instruction
//   exc_ack                    control unit consumed the exception record
//   ex_*                       registered EX-stage control and PC
//   ovf_kill                   combinational write-back suppress
//   exc_pending, exc_pc        sticky overflow exception and its PC
module alu_op_issue
   import alu_pkg::*;
#(
   parameter int unsigned         PC_W   = 32,
   parameter logic [ALU_OP_W-1:0] NOP_OP = ALU_NOP
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                id_valid,
   input  logic [OPC_W-1:0]    id_opcode,
   input  logic [FUNCT_W-1:0]  id_funct,
   input  logic [PC_W-1:0]     id_pc,
   input  logic                stall,
   input  logic                flush,
   input  logic                alu_overflow,
   input  logic                exc_ack,
   output logic                ex_valid,
   output logic [ALU_OP_W-1:0] ex_alu_operation,
   output logic                ex_alu_src,
   output logic [PC_W-1:0]     ex_pc,
   output logic                ex_illegal,
   output logic                ovf_kill,
   output logic                exc_pending,
   output logic [PC_W-1:0]     exc_pc
);

   dec_t id_dec;
   dec_t ex_dec;
   logic exc_set;

   alu_op_decode #(.NOP_OP(NOP_OP)) u_decode (
      .opcode    (id_opcode),
      .funct     (id_funct),
      .op_c      (id_dec.op),
      .alu_src_c (id_dec.alu_src),
      .trap_c    (id_dec.trap),
      .illegal_c (id_dec.illegal)
   );

   // ID/EX register: reset > flush > stall > load; an invalid ID loads a bubble
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         ex_valid <= 1'b0;
         ex_dec   <= dec_bubble(NOP_OP);
         ex_pc    <= '0;
      end else if (!stall) begin
         ex_valid <= id_valid;
         ex_dec   <= id_valid ? id_dec : dec_bubble(NOP_OP);
         ex_pc    <= id_valid ? id_pc : '0;
      end
   end

   assign ex_alu_operation = ex_dec.op;
   assign ex_alu_src       = ex_dec.alu_src;
   assign ex_illegal       = ex_dec.illegal;

   assign ovf_kill = ex_valid & ex_dec.trap & alu_overflow;

   // Capture only on an unstalled cycle so a held instruction is recorded once;
   // a coincident ack frees the record for the new event.
   assign exc_set = ovf_kill & ~stall & (~exc_pending | exc_ack);

   // Sticky exception record; exc_pc is kept after ack
   always_ff @(posedge clk) begin
      if (reset) begin
         exc_pending <= 1'b0;
         exc_pc      <= '0;
      end else if (exc_set) begin
         exc_pending <= 1'b1;
         exc_pc      <= ex_pc;
      end else if (exc_ack) begin
         exc_pending <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_op_issue.sv
module tb_alu_op_issue;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        id_valid = 1'b0;
   logic [5:0]  id_opcode = '0;
   logic [5:0]  id_funct = '0;
   logic [31:0] id_pc = '0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        alu_overflow = 1'b0;
   logic        exc_ack = 1'b0;
   logic        ex_valid;
   logic [3:0]  ex_alu_operation;
   logic        ex_alu_src;
   logic [31:0] ex_pc;
   logic        ex_illegal;
   logic        ovf_kill;
   logic        exc_pending;
   logic [31:0] exc_pc;

   alu_op_issue dut (
      .clk              (clk),
      .reset            (reset),
      .id_valid         (id_valid),
      .id_opcode        (id_opcode),
      .id_funct         (id_funct),
      .id_pc            (id_pc),
      .stall            (stall),
      .flush            (flush),
      .alu_overflow     (alu_overflow),
      .exc_ack          (exc_ack),
      .ex_valid         (ex_valid),
      .ex_alu_operation (ex_alu_operation),
      .ex_alu_src       (ex_alu_src),
      .ex_pc            (ex_pc),
      .ex_illegal       (ex_illegal),
      .ovf_kill         (ovf_kill),
      .exc_pending      (exc_pending),
      .exc_pc           (exc_pc)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Instruction tables
   logic [5:0] r_fn  [6] = '{6'h20, 6'h22, 6'h18, 6'h26, 6'h2A, 6'h27};
   logic [3:0] r_op  [6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0011, 4'b0111, 4'b1100};
   logic       r_tr  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   logic [5:0] i_opc [6] = '{6'h08, 6'h23, 6'h2B, 6'h0A, 6'h0E, 6'h04};
   logic [3:0] i_op  [6] = '{4'b0010, 4'b0010, 4'b0010, 4'b0111, 4'b0011, 4'b0110};
   logic       i_src [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
   logic       i_tr  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

   // Reference state
   logic        m_valid = 1'b0;
   logic [3:0]  m_op = 4'hF;
   logic        m_src = 1'b0;
   logic [31:0] m_pc = '0;
   logic        m_ill = 1'b0;
   logic        m_trap = 1'b0;
   logic        m_pend = 1'b0;
   logic [31:0] m_epc = '0;
   bit          primed = 1'b0;

   task automatic ref_dec(input logic [5:0] opc, input logic [5:0] fn,
                          output logic [3:0] op, output logic src,
                          output logic tr, output logic ill);
      op = 4'hF; src = 1'b0; tr = 1'b0; ill = 1'b1;
      if (opc == 6'h00) begin
         for (int i = 0; i < 6; i++)
            if (fn == r_fn[i]) begin op = r_op[i]; tr = r_tr[i]; ill = 1'b0; end
      end else begin
         for (int i = 0; i < 6; i++)
            if (opc == i_opc[i]) begin
               op = i_op[i]; src = i_src[i]; tr = i_tr[i]; ill = 1'b0;
            end
      end
   endtask

   // One clock: drive inputs, check kill, advance model, check registered outputs
   task automatic cycle(input logic v, input logic [5:0] opc, input logic [5:0] fn,
                        input logic [31:0] pc, input logic st, input logic fl,
                        input logic ovf, input logic ack, input logic rst);
      logic kill;
      logic [3:0] d_op;
      logic d_src, d_tr, d_ill;
      id_valid = v; id_opcode = opc; id_funct = fn; id_pc = pc;
      stall = st; flush = fl; alu_overflow = ovf; exc_ack = ack; reset = rst;
      #1;
      kill = m_valid & m_trap & ovf;
      if (primed) check("ovf_kill", 32'(ovf_kill), 32'(kill));
      if (rst) begin
         m_valid = 0; m_op = 4'hF; m_src = 0; m_pc = 0; m_ill = 0; m_trap = 0;
         m_pend = 0; m_epc = 0;
      end else begin
         if (kill && !st && (!m_pend || ack)) begin
            m_pend = 1'b1; m_epc = m_pc;
         end else if (ack) m_pend = 1'b0;
         if (fl || (!st && !v)) begin
            m_valid = 0; m_op = 4'hF; m_src = 0; m_pc = 0; m_ill = 0; m_trap = 0;
         end else if (!st) begin
            ref_dec(opc, fn, d_op, d_src, d_tr, d_ill);
            m_valid = 1; m_op = d_op; m_src = d_src; m_pc = pc; m_ill = d_ill; m_trap = d_tr;
         end
      end
      @(posedge clk);
      @(negedge clk);
      primed = 1'b1;
      check("ex_valid", 32'(ex_valid), 32'(m_valid));
      check("ex_alu_operation", 32'(ex_alu_operation), 32'(m_op));
      check("ex_alu_src", 32'(ex_alu_src), 32'(m_src));
      check("ex_pc", ex_pc, m_pc);
      check("ex_illegal", 32'(ex_illegal), 32'(m_ill));
      check("exc_pending", 32'(exc_pending), 32'(m_pend));
      check("exc_pc", exc_pc, m_epc);
   endtask

   task automatic idle(input logic st, input logic ovf, input logic ack);
      cycle(1'b0, 6'h00, 6'h00, 32'h0, st, 1'b0, ovf, ack, 1'b0);
   endtask

   initial begin
      logic [5:0] opc, fn;
      @(negedge clk);
      cycle(0, 6'h00, 6'h00, 32'h0, 0, 0, 0, 0, 1);
      cycle(0, 6'h00, 6'h00, 32'h0, 0, 0, 0, 0, 1);
      check("reset_op", 32'(ex_alu_operation), 32'h0000000F);
      check("reset_valid", 32'(ex_valid), 32'h0);

      // Issue sequence
      cycle(1, 6'h00, 6'h20, 32'h100, 0, 0, 0, 0, 0);
      check("add_op", 32'(ex_alu_operation), 32'h2);
      cycle(1, 6'h0E, 6'h00, 32'h104, 0, 0, 0, 0, 0);
      check("xori_src", 32'(ex_alu_src), 32'h1);
      cycle(1, 6'h04, 6'h11, 32'h108, 0, 0, 0, 0, 0);
      check("beq_op", 32'(ex_alu_operation), 32'h6);

      // Illegal encoding
      cycle(1, 6'h3F, 6'h00, 32'h10C, 0, 0, 0, 0, 0);
      check("illegal_flag", 32'(ex_illegal), 32'h1);

      // Stall hold, then stall+flush
      cycle(1, 6'h00, 6'h22, 32'h110, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cycle(1, 6'h08, 6'h00, 32'h114 + 32'(i), 1, 0, 0, 0, 0);
      check("stall_hold_op", 32'(ex_alu_operation), 32'h6);
      cycle(1, 6'h08, 6'h00, 32'h120, 1, 1, 0, 0, 0);
      check("flush_valid", 32'(ex_valid), 32'h0);

      // Overflow trap, second overflow ignored
      cycle(1, 6'h00, 6'h20, 32'h200, 0, 0, 0, 0, 0);
      cycle(1, 6'h00, 6'h20, 32'h204, 0, 0, 1, 0, 0);
      check("trap_pc", exc_pc, 32'h200);
      cycle(1, 6'h23, 6'h00, 32'h208, 0, 0, 1, 0, 0);
      check("trap_first_kept", exc_pc, 32'h200);

      // Non-trapping overflow (lw in EX), after ack
      cycle(0, 6'h00, 6'h00, 32'h0, 0, 0, 1, 1, 0);
      check("ack_clear", 32'(exc_pending), 32'h0);

      // Ack coincident with new trap
      cycle(1, 6'h00, 6'h20, 32'h300, 0, 0, 0, 0, 0);
      cycle(1, 6'h00, 6'h20, 32'h304, 0, 0, 1, 0, 0);
      cycle(0, 6'h00, 6'h00, 32'h0, 0, 0, 1, 1, 0);
      cycle(1, 6'h00, 6'h20, 32'h300, 0, 0, 0, 0, 0);
      cycle(0, 6'h00, 6'h00, 32'h0, 0, 0, 1, 1, 0);
      check("ack_new_pc", exc_pc, 32'h300);

      // Stalled trapping instruction recorded once, then reset mid-stall
      cycle(1, 6'h08, 6'h00, 32'h400, 0, 0, 0, 1, 0);
      idle(1, 1, 0);
      idle(1, 1, 0);
      idle(0, 1, 0);
      check("stall_capture_pc", exc_pc, 32'h400);
      cycle(1, 6'h00, 6'h20, 32'h404, 0, 0, 0, 0, 0);
      cycle(1, 6'h00, 6'h20, 32'h408, 1, 0, 1, 0, 1);
      check("reset_pend", 32'(exc_pending), 32'h0);

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: begin
               opc = i_opc[$urandom_range(0, 5)]; fn = 6'($urandom);
            end
            6, 7: begin
               opc = 6'h00;
               fn = ($urandom_range(0, 3) != 0) ? r_fn[$urandom_range(0, 5)] : 6'($urandom);
            end
            default: begin opc = 6'($urandom); fn = 6'($urandom); end
         endcase
         cycle(1'($urandom_range(0, 9) != 0), opc, fn, $urandom & 32'hFFFF_FFFC,
               1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 9) == 0),
               1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 4) == 0),
               1'($urandom_range(0, 49) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
